exe_mwb_skid_reg: RTL
=====================

# exe_mwb_skid_reg

Parametrised EXE→MWB pipeline stage register with a valid/ready handshake and a two-entry skid buffer, so the downstream stage can stall without a combinational ready path back into EXE. It carries the instruction, PC, a configurable-width datapath bundle (ALU result, immediate, I/O-memory data) and a configurable-width control bundle (register write enable, DMEM select, load select, writeback select). It supports pipeline flush with bubble insertion and counts downstream stall cycles.

## Interface
- DATA_W, 96: datapath bundle width; default is ALU result, immediate and iomem data, 32 bits each.
- CTRL_W, 8: control bundle width; default is Reg_WE 1, DMEM_sel 2, LOAD_sel 3, WB_sel 2.
- NOP_INSTR, 32'h0000_0013: instruction word driven for a bubble.
- CNT_W, 16: stall counter width.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- pc_rst  in  32  value loaded into pc_out on reset.
- flush  in  1  discard all held and incoming beats.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  this block accepts a beat this cycle.
- instr_in  in  32  instruction word.
- pc_in  in  32  PC.
- data_in  in  DATA_W  datapath bundle.
- ctrl_in  in  CTRL_W  control bundle.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts.
- instr_out  out  32  registered instruction.
- pc_out  out  32  registered PC.
- data_out  out  DATA_W  registered datapath bundle.
- ctrl_out  out  CTRL_W  registered control bundle.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  saturating count of downstream-stall cycles.

## Operation
- Storage:
  - Main register M drives all outputs directly.
  - Skid register S holds one extra beat.
  - State encodes occupancy: EMPTY (M and S empty), ONE (M valid), TWO (M and S valid).
- Signal definitions:
  - out_valid = state is ONE or TWO.
  - in_ready = state is not TWO AND flush is 0.
  - Accept (acc) = in_valid AND in_ready.
  - Drain (drn) = out_valid AND out_ready.
- Transitions; priority is rst, then flush, then normal:
  - EMPTY: acc → M loads input, go to ONE.
  - ONE: acc and drn → M loads input, stay in ONE. acc only → S loads input, go to TWO. drn only → M loads bubble, go to EMPTY. Neither → hold.
  - TWO: drn → M loads S, go to ONE. Otherwise hold.
- Bubble definition: instr = NOP_INSTR, ctrl = 0, data = 0, pc unchanged.
- flush (rst = 0):
  - Next state is EMPTY.
  - M loads a bubble.
  - S content is discarded.
  - in_ready = 0 in the flush cycle, so no beat is accepted.
  - A drain in the flush cycle still completes: downstream consumed M's old value.
- rst:
  - State goes to EMPTY; S is cleared.
  - instr_out = NOP_INSTR, pc_out = pc_rst, data_out = 0, ctrl_out = 0, stall_cnt = 0.
  - Reset value of in_ready: 1 once rst deasserts (state EMPTY).
  - Reset value of out_valid: 0.
- stall_cnt:
  - Increments by 1 each cycle with out_valid = 1 and out_ready = 0.
  - Saturates at 2^CNT_W − 1.
  - cnt_clr forces 0 and wins over increment.
  - flush does not affect it.
- Ordering: beats leave in acceptance order, with none lost or duplicated, except beats discarded by flush.
- Payload is not required to be stable when the matching valid is 0.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on the outputs with out_valid = 1 after edge N.
- Throughput is 1 beat/cycle when out_ready is held at 1; S remains unused.
- in_ready is a function of registered state and flush only. There is no combinational path from out_ready to in_ready.
- Downstream stall timing:
  - When out_ready drops while a beat is accepted, that beat goes to S and in_ready falls on the next cycle.
  - At most one extra beat is absorbed.
- After TWO→ONE, in_ready returns to 1 in the next cycle.
- All outputs are registered except in_ready, which is also gated by flush.

## Test plan
- Reset with pc_rst = 32'h0000_1000 → instr_out = 32'h13, pc_out = 32'h1000, data/ctrl = 0, out_valid = 0, in_ready = 1, stall_cnt = 0.
- Streaming: out_ready = 1, 8 beats with pc 0,4,…,28 on consecutive cycles → same 8 pcs appear one cycle later with no gaps; stall_cnt stays 0.
- Skid: stream beats A,B,C and drop out_ready when B is accepted; hold low 3 cycles → in_ready goes 0 after B, C is held upstream, A is output and held, stall_cnt = 3; raise out_ready → outputs A,B,C in order and in_ready returns to 1.
- Flush in state TWO with in_valid = 1 → next cycle out_valid = 0, instr_out = NOP_INSTR, ctrl_out = 0; neither S content nor the incoming beat ever appears.
- Flush and drain together in state ONE → the drained beat is counted as consumed, state goes EMPTY, and the next accepted beat appears normally.
- With CNT_W = 4, out_valid = 1 and out_ready = 0 for 20 cycles → stall_cnt saturates at 15. Then cnt_clr coincident with a stall cycle → stall_cnt = 0.

Source files
------------

// File: rtl/exe_mwb_skid_reg.sv
// EXE->MWB pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// The main register drives all outputs; the skid register absorbs one beat when downstream stalls.
module exe_mwb_skid_reg #(
    parameter int          DATA_W    = 96,
    parameter int          CTRL_W    = 8,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr_in,
    input  logic [31:0]       pc_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr_out,
    output logic [31:0]       pc_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CTRL_W-1:0] ctrl_out,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t              state_q, state_d;
    logic [31:0]         mInstr_q, mInstr_d;
    logic [31:0]         mPc_q, mPc_d;
    logic [DATA_W-1:0]   mData_q, mData_d;
    logic [CTRL_W-1:0]   mCtrl_q, mCtrl_d;
    logic [31:0]         sInstr_q, sInstr_d;
    logic [31:0]         sPc_q, sPc_d;
    logic [DATA_W-1:0]   sData_q, sData_d;
    logic [CTRL_W-1:0]   sCtrl_q, sCtrl_d;
    logic [CNT_W-1:0]    stallCnt_q, stallCnt_d;
    logic                acc;
    logic                drn;

    // in_ready depends only on registered occupancy and flush, never on out_ready
    assign in_ready  = (state_q != TWO) && !flush;
    assign out_valid = (state_q == ONE) || (state_q == TWO);
    assign acc       = in_valid && in_ready;
    assign drn       = out_valid && out_ready;

    assign instr_out = mInstr_q;
    assign pc_out    = mPc_q;
    assign data_out  = mData_q;
    assign ctrl_out  = mCtrl_q;
    assign stall_cnt = stallCnt_q;

    always_comb begin
        state_d  = state_q;
        mInstr_d = mInstr_q;
        mPc_d    = mPc_q;
        mData_d  = mData_q;
        mCtrl_d  = mCtrl_q;
        sInstr_d = sInstr_q;
        sPc_d    = sPc_q;
        sData_d  = sData_q;
        sCtrl_d  = sCtrl_q;

        if (flush) begin
            // bubble keeps the old pc; skid content is simply abandoned
            state_d  = EMPTY;
            mInstr_d = NOP_INSTR;
            mData_d  = '0;
            mCtrl_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d  = ONE;
                        mInstr_d = instr_in;
                        mPc_d    = pc_in;
                        mData_d  = data_in;
                        mCtrl_d  = ctrl_in;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        mInstr_d = instr_in;
                        mPc_d    = pc_in;
                        mData_d  = data_in;
                        mCtrl_d  = ctrl_in;
                    end else if (acc) begin
                        state_d  = TWO;
                        sInstr_d = instr_in;
                        sPc_d    = pc_in;
                        sData_d  = data_in;
                        sCtrl_d  = ctrl_in;
                    end else if (drn) begin
                        state_d  = EMPTY;
                        mInstr_d = NOP_INSTR;
                        mData_d  = '0;
                        mCtrl_d  = '0;
                    end
                end
                TWO: begin
                    if (drn) begin
                        state_d  = ONE;
                        mInstr_d = sInstr_q;
                        mPc_d    = sPc_q;
                        mData_d  = sData_q;
                        mCtrl_d  = sCtrl_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // saturating stall counter; clear wins over increment
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (cnt_clr) begin
            stallCnt_d = '0;
        end else if (out_valid && !out_ready && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            mInstr_q   <= NOP_INSTR;
            mPc_q      <= pc_rst;
            mData_q    <= '0;
            mCtrl_q    <= '0;
            sInstr_q   <= '0;
            sPc_q      <= '0;
            sData_q    <= '0;
            sCtrl_q    <= '0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mInstr_q   <= mInstr_d;
            mPc_q      <= mPc_d;
            mData_q    <= mData_d;
            mCtrl_q    <= mCtrl_d;
            sInstr_q   <= sInstr_d;
            sPc_q      <= sPc_d;
            sData_q    <= sData_d;
            sCtrl_q    <= sCtrl_d;
            stallCnt_q <= stallCnt_d;
        end
    end

endmodule
